// File: rtl/vec_wb_serializer.sv
// Serializes a bundle of ALU lane results onto one register-file write port and folds lane flags.
// Optional lane skipping is enabled by defining VEC_WB_LANE_MASK_EN.
module vec_wb_serializer #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int RD_W   = 4,
    parameter int LANE_W = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_result,
    input  logic [LANES*4-1:0]      in_flags,
    input  logic                    in_scalar,
    input  logic [RD_W-1:0]         in_rd,
`ifdef VEC_WB_LANE_MASK_EN
    input  logic [LANES-1:0]        in_mask,
`endif
    input  logic                    wb_stall,
    output logic                    wb_en,
    output logic [RD_W-1:0]         wb_rd,
    output logic [LANE_W-1:0]       wb_lane,
    output logic [DATA_W-1:0]       wb_data,
    output logic [3:0]              flags_out,
    output logic                    flags_valid,
    output logic                    busy
);

    // state | meaning
    // IDLE  | waiting for a bundle, in_ready=1
    // WRITE | one lane per unstalled cycle, lane = cnt_q
    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t                  state_q;
    logic [LANE_W-1:0]       cnt_q;
    logic [LANES-1:0]        mask_q;
    logic [LANES*DATA_W-1:0] res_q;
    logic [LANES*4-1:0]      flg_q;
    logic [RD_W-1:0]         rd_q;
    logic [3:0]              flags_out_q;
    logic                    flags_valid_q;

    logic [LANES-1:0]        in_eff_mask;
    logic [LANE_W-1:0]       last_lane;
    logic [LANE_W-1:0]       next_lane_d;
    logic [LANE_W-1:0]       first_lane;
    logic [3:0]              agg;
    logic                    retire;
    logic                    retire_last;
    logic                    accept;

    // Scalar mode is folded into the lane mask: only lane 0 is ever visited.
`ifdef VEC_WB_LANE_MASK_EN
    assign in_eff_mask = in_scalar ? LANES'(1) : in_mask;
`else
    assign in_eff_mask = in_scalar ? LANES'(1) : {LANES{1'b1}};
`endif

    always_comb begin
        last_lane   = '0;
        first_lane  = '0;
        next_lane_d = cnt_q;
        agg         = 4'b0010;
        for (int i = 0; i < LANES; i++) begin
            if (mask_q[i]) last_lane = LANE_W'(i);
        end
        for (int i = LANES - 1; i >= 0; i--) begin
            if (in_eff_mask[i]) first_lane = LANE_W'(i);
            if (mask_q[i] && (i > int'(cnt_q))) next_lane_d = LANE_W'(i);
        end
        // carry/negative/overflow are ORed, zero is ANDed across visited lanes
        for (int i = 0; i < LANES; i++) begin
            if (mask_q[i]) begin
                agg[0] = agg[0] | flg_q[i*4 + 0];
                agg[1] = agg[1] & flg_q[i*4 + 1];
                agg[2] = agg[2] | flg_q[i*4 + 2];
                agg[3] = agg[3] | flg_q[i*4 + 3];
            end
        end
    end

    assign retire      = (state_q == WRITE) && !wb_stall;
    assign retire_last = retire && (cnt_q == last_lane);
    assign in_ready    = (state_q == IDLE) || retire_last;
    assign accept      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mask_q        <= '0;
            res_q         <= '0;
            flg_q         <= '0;
            rd_q          <= '0;
            flags_out_q   <= '0;
            flags_valid_q <= 1'b0;
        end else begin
            flags_valid_q <= 1'b0;
            if (retire_last) begin
                flags_out_q   <= agg;
                flags_valid_q <= 1'b1;
                state_q       <= IDLE;
            end else if (retire) begin
                cnt_q <= next_lane_d;
            end
            // an accept on the last-beat edge overrides the return to IDLE
            if (accept) begin
                res_q  <= in_result;
                flg_q  <= in_flags;
                rd_q   <= in_rd;
                mask_q <= in_eff_mask;
                cnt_q  <= first_lane;
                if (in_eff_mask == '0) begin
                    flags_out_q   <= 4'b0000;
                    flags_valid_q <= 1'b1;
                    state_q       <= IDLE;
                end else begin
                    state_q <= WRITE;
                end
            end
        end
    end

    assign wb_en       = (state_q == WRITE);
    assign busy        = (state_q == WRITE);
    assign wb_rd       = rd_q;
    assign wb_lane     = cnt_q;
    assign wb_data     = res_q[cnt_q*DATA_W +: DATA_W];
    assign flags_out   = flags_out_q;
    assign flags_valid = flags_valid_q;

endmodule
